request_encoder: RTL and testbench
==================================

// Module: request_encoder
// PURPOSE
//  Sequential 4-to-2 request encoder; the encoding end of the 2-to-4 address decoder.
//  - Collects request lines in0..in3 into sticky pending bits.
//  - Issues one request at a time as {address1,address0} with valid.
//  - Holds the grant until the consumer acks; an optional timeout drops it.
//  - Outputs wire straight into the decoder: address0/address1 -> address0/address1, valid -> enable.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles a grant may wait for ack before it is dropped; 0 = wait forever
//  CNT_W         5  timeout counter width; must satisfy 2**CNT_W > ACK_TIMEOUT
// PORTS
//  clk       in   1  rising-edge clock
//  reset     in   1  synchronous, active-high reset
//  in0..in3  in   1  request lines (level); any number may be high at once
//  ack       in   1  consumer accepts the current grant; ignored while valid=0
//  address0  out  1  granted index, bit 0 (registered)
//  address1  out  1  granted index, bit 1 (registered)
//  valid     out  1  address0/address1 hold a live grant (registered)
//  err       out  1  one-cycle pulse when a grant is dropped by timeout
//  busy      out  1  valid | (pending != 0)
// BEHAVIOUR
//  - Reset, synchronous on clk, active-high:
//    - valid=0, address1/address0=00, err=0, pending=0000, rr_ptr=0, state=IDLE.
//    - Reset during GRANT discards the grant and all pending requests.
//  - pending_next = pending | {in3,in2,in1,in0}, evaluated every cycle.
//  - IDLE:
//    - If pending_next != 0: pick index k (see CONFIGURATION), load address<=k, valid<=1,
//      pending<=pending_next, tmo_cnt<=0, go to GRANT.
//    - Otherwise stay in IDLE.
//    - Latency: a request seen at edge t gives valid=1 after edge t.
//  - GRANT:
//    - address and valid hold steady; pending |= in.
//    - ack=1: clear pending[k], then OR in the same-cycle in (a re-asserted in[k] stays pending).
//      Also valid<=0, rr_ptr<=k+1 mod 4, go to IDLE.
//    - No ack, ACK_TIMEOUT!=0, tmo_cnt==ACK_TIMEOUT-1: clear pending[k] as for ack.
//      Also err<=1 for one cycle, valid<=0, rr_ptr<=k+1 mod 4, go to IDLE.
//    - Otherwise tmo_cnt++.
//    - If ack and timeout fall in the same cycle, ack wins and err stays 0.
//  - There is a mandatory one-cycle bubble (valid=0) between grants: maximum one grant per 2 cycles.
//  - tmo_cnt saturates and never wraps; it is cleared on entry to GRANT.
//  - address is don't-care while valid=0 but holds its last value (no glitching into the decoder).
// CONFIGURATION
//  Macro ROUND_ROBIN_EN:
//  - Defined: the search starts at rr_ptr and wraps 3->0. The first set bit of pending_next wins,
//    so no requester starves.
//  - Undefined: fixed priority, lowest index wins (in0 highest). rr_ptr is still maintained but unused.
// STRUCTURE
//  Shared header encoder_defs.vh:
//  - `define ENC_IDLE 1'b0 / ENC_GRANT 1'b1 state codes
//  - `define ENC_N 4 requester count
//  Sub-module priority_pick: combinational, 4-bit req + 2-bit start -> 2-bit idx + any.
//  - Instantiated once; start is tied to 2'b00 when ROUND_ROBIN_EN is undefined.
//  Top level holds state, pending, rr_ptr, tmo_cnt and the output registers.
// TESTING
//  Check every case with and without ROUND_ROBIN_EN; loop valid/address into structuralDecoder.
//  1. Reset: hold reset 2 cycles with in=1111 -> valid=0, address=00, busy=0, err=0.
//  2. in2 pulsed 1 cycle -> next cycle valid=1, addr=10, decoder out2 only.
//     Ack 3 cycles later -> valid=0 next cycle, busy=0.
//  3. in=1111 held, ack every grant:
//     - RR: grants 0,1,2,3,0 with valid low between each.
//     - Fixed: grant 0 repeatedly.
//  4. ACK_TIMEOUT=4, in1 pulsed, no ack -> valid high exactly 4 cycles, err=1 one cycle, pending[1]=0.
//  5. Ack and timeout in the same cycle -> err=0. Reset asserted mid-GRANT -> valid=0 and pending=0 next cycle.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// Shared definitions for the request encoder: requester count, FSM state type and
// an index-to-one-hot helper.
package request_encoder_pkg;

   localparam int unsigned EncN = 4;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } enc_state_e;

   function automatic logic [EncN-1:0] idx_onehot(input logic [1:0] idx);
      idx_onehot = EncN'(1) << idx;
   endfunction

endpackage

// File: rtl/request_encoder_priority_pick.sv
// Combinational picker: first set request bit at or above start, wrapping 3->0.
module request_encoder_priority_pick
   import request_encoder_pkg::*;
(
   input  logic [EncN-1:0] req,
   input  logic [1:0]      start,
   output logic [1:0]      idx,
   output logic            any
);

   logic [1:0] j;

   // Scan from start upward; the first hit is kept.
   always_comb begin
      idx = 2'b00;
      any = 1'b0;
      j   = 2'b00;
      for (int i = 0; i < EncN; i++) begin
         j = start + 2'(i);
         if (!any && req[j]) begin
            idx = j;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/request_encoder.sv
// Sequential 4-to-2 request encoder. Requests are held as sticky pending bits and
// granted one at a time as {address1,address0}/valid until acked or timed out.
// Build option: define ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest pending index always wins.
module request_encoder
   import request_encoder_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   input  logic ack,
   output logic address0,
   output logic address1,
   output logic valid,
   output logic err,
   output logic busy
);

   localparam bit TmoEn = (ACK_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TmoLast = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

   enc_state_e       state;
   logic [EncN-1:0]  req_in;
   logic [EncN-1:0]  pending;
   logic [EncN-1:0]  pending_next;
   logic [EncN-1:0]  pending_drop;
   logic [1:0]       addr;
   logic [1:0]       rr_ptr;
   logic [1:0]       start;
   logic [1:0]       pick_idx;
   logic             pick_any;
   logic [CNT_W-1:0] tmo_cnt;

   assign req_in       = {in3, in2, in1, in0};
   assign pending_next = pending | req_in;
   // A same-cycle re-request of the granted line survives the clear.
   assign pending_drop = (pending & ~idx_onehot(addr)) | req_in;

`ifdef ROUND_ROBIN_EN
   assign start = rr_ptr;
`else
   assign start = 2'b00;
   logic unused_rr;
   assign unused_rr = ^rr_ptr;
`endif

   request_encoder_priority_pick u_pick (
      .req   (pending_next),
      .start (start),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Grant FSM with registered address/valid/err outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= StIdle;
         addr    <= 2'b00;
         valid   <= 1'b0;
         err     <= 1'b0;
         pending <= '0;
         rr_ptr  <= 2'b00;
         tmo_cnt <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            StIdle: begin
               pending <= pending_next;
               if (pick_any) begin
                  addr    <= pick_idx;
                  valid   <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= StGrant;
               end
            end
            StGrant: begin
               if (ack) begin
                  pending <= pending_drop;
                  valid   <= 1'b0;
                  rr_ptr  <= addr + 2'd1;
                  state   <= StIdle;
               end else if (TmoEn && (tmo_cnt == TmoLast)) begin
                  pending <= pending_drop;
                  err     <= 1'b1;
                  valid   <= 1'b0;
                  rr_ptr  <= addr + 2'd1;
                  state   <= StIdle;
               end else begin
                  pending <= pending_next;
                  // Saturate rather than wrap.
                  if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign address0 = addr[0];
   assign address1 = addr[1];
   assign busy     = valid | (|pending);

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder (timeout set to 4 cycles). Follows
// ROUND_ROBIN_EN the same way the design does.
module tb_request_encoder;

   localparam int Tmo = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in = 4'b0000;
   logic       ack = 1'b0;
   logic       address0, address1, valid, err, busy;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   bit [3:0] m_pend  = '0;
   bit       m_valid = 1'b0;
   bit       m_err   = 1'b0;
   int       m_addr  = 0;
   int       m_rr    = 0;
   int       m_wait  = 0;

   request_encoder #(
      .ACK_TIMEOUT (Tmo),
      .CNT_W       (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in0      (in[0]),
      .in1      (in[1]),
      .in2      (in[2]),
      .in3      (in[3]),
      .ack      (ack),
      .address0 (address0),
      .address1 (address1),
      .valid    (valid),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic int pick(bit [3:0] p, int from);
      for (int i = 0; i < 4; i++) begin
         if (p[(from + i) % 4]) return (from + i) % 4;
      end
      return 0;
   endfunction

   // One clock of the arbitration rules, from the inputs seen at this edge.
   task automatic model_step();
      bit [3:0] seen;
      seen = m_pend | in;
      if (reset) begin
         m_pend = '0; m_valid = 0; m_err = 0; m_addr = 0; m_rr = 0; m_wait = 0;
         return;
      end
      m_err = 0;
      if (!m_valid) begin
         m_pend = seen;
         if (seen != 0) begin
`ifdef ROUND_ROBIN_EN
            m_addr = pick(seen, m_rr);
`else
            m_addr = pick(seen, 0);
`endif
            m_valid = 1;
            m_wait  = 0;
         end
      end else if (ack || (m_wait + 1 == Tmo)) begin
         m_pend[m_addr] = 1'b0;
         m_pend  = m_pend | in;
         m_err   = !ack;
         m_valid = 0;
         m_rr    = (m_addr + 1) % 4;
      end else begin
         m_pend = seen;
         m_wait++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in = 4'b0000; ack = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in = 4'b1111; ack = 1'b0;
      tick(); tick();
      n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
      n_vec++; if ({address1, address0} !== 2'b00) begin
         n_bad++; $display("FAIL reset_addr got %b want 00", {address1, address0}); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
      reset = 1'b0; in = 4'b0000;
      tick();
   endtask

   task automatic test_single();
      in = 4'b0100;
      tick();
      in = 4'b0000;
      n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", valid); end
      n_vec++; if ({address1, address0} !== 2'b10) begin
         n_bad++; $display("FAIL single_addr got %b want 10", {address1, address0}); end
      tick(); tick();
      n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_hold got %b want 1", valid); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_ack_valid got %b want 0", valid); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_ack_busy got %b want 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_ack_err got %b want 0", err); end
   endtask

   task automatic test_back_to_back();
      int want;
      do_reset();
      in = 4'b1111; ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i % 2 == 0) begin
`ifdef ROUND_ROBIN_EN
            want = (i / 2) % 4;
`else
            want = 0;
`endif
            n_vec++; if (valid !== 1'b1 || {address1, address0} !== 2'(want)) begin
               n_bad++;
               $display("FAIL b2b_grant%0d got v=%b a=%0d want v=1 a=%0d", i / 2, valid,
                        {address1, address0}, want);
            end
         end else begin
            n_vec++; if (valid !== 1'b0) begin
               n_bad++; $display("FAIL b2b_bubble%0d got v=%b want 0", i / 2, valid); end
         end
      end
      in = 4'b0000; ack = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      in = 4'b0010;
      tick();
      in = 4'b0000;
      n_vec++; if ({address1, address0} !== 2'b01) begin
         n_bad++; $display("FAIL tmo_addr got %b want 01", {address1, address0}); end
      for (int i = 0; i < Tmo; i++) begin
         n_vec++; if (valid !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL tmo_hold%0d got v=%b e=%b want v=1 e=0", i, valid, err); end
         if (i < Tmo - 1) tick();
      end
      tick();
      n_vec++; if (valid !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL tmo_drop got v=%b e=%b b=%b want v=0 e=1 b=0", valid, err, busy); end
      tick();
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got %b want 0", err); end
   endtask

   task automatic test_ack_at_timeout();
      do_reset();
      in = 4'b0010;
      tick();
      in = 4'b0000;
      for (int i = 0; i < Tmo - 1; i++) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_vec++; if (valid !== 1'b0 || err !== 1'b0) begin
         n_bad++; $display("FAIL ack_tmo got v=%b e=%b want v=0 e=0", valid, err); end
      tick();
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ack_tmo_late got %b want 0", err); end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      in = 4'b1011;
      tick();
      in = 4'b0000;
      n_vec++; if (valid !== 1'b1 || {address1, address0} !== 2'b00) begin
         n_bad++; $display("FAIL mid_grant got v=%b a=%b want v=1 a=00", valid, {address1, address0}); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++; if (valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset got v=%b b=%b want v=0 b=0", valid, busy); end
      tick();
      n_vec++; if (valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_after got v=%b b=%b want v=0 b=0", valid, busy); end
   endtask

   task automatic test_random();
      int a;
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         in    = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
         ack   = ($urandom_range(0, 9) < 3);
         tick();
         a = {address1, address0};
         n_vec++;
         if (valid !== m_valid || a != m_addr || err !== m_err
             || busy !== (m_valid || (m_pend != 0))) begin
            n_bad++;
            $display("FAIL rand%0d got v=%b a=%0d e=%b b=%b want v=%b a=%0d e=%b b=%b", c, valid,
                     a, err, busy, m_valid, m_addr, m_err, (m_valid || (m_pend != 0)));
         end
      end
      reset = 1'b0; in = 4'b0000; ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
